instruction_cache: RTL and testbench

Direct-mapped, read-only instruction cache answering the instruction unit's fetch port. Each cycle it reports hit/instruction combinationally for the presented fetch address. On a miss it refills the whole 4-word line from the memory controller over a word-level request/done handshake. It sits between the instruction unit (fetch side) and the memory controller (refill side).

---
 rtl/instruction_cache_pkg.sv | 19 +
 rtl/icache_line_array.sv | 51 +++++
 rtl/instruction_cache.sv | 132 +++++++++++++
 tb/tb_instruction_cache.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM encoding,
// line geometry and address-field positions.
package instruction_cache_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  localparam int LINE_WORDS = 4;
  localparam int OFFSET_LSB = 2;
  localparam int INDEX_LSB  = 4;

  // Tag covers every address bit above the line index.
  function automatic int tag_width(input int index_width);
    return 32 - INDEX_LSB - index_width;
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache: one asynchronous read
// port and one synchronous write port (word write, tag+valid set, valid clear).
module icache_line_array
  import instruction_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = 4,
  parameter int TAG_WIDTH   = tag_width(INDEX_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] rd_index,
  input  logic [1:0]             rd_offset,
  output logic                   rd_valid,
  output logic [TAG_WIDTH-1:0]   rd_tag,
  output logic [31:0]            rd_data,
  input  logic                   clr_en,
  input  logic [INDEX_WIDTH-1:0] clr_index,
  input  logic                   word_en,
  input  logic                   set_en,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic [1:0]             wr_offset,
  input  logic [31:0]            wr_data,
  input  logic [TAG_WIDTH-1:0]   wr_tag
);

  localparam int LINES = 1 << INDEX_WIDTH;

  logic [LINES-1:0]     valid;
  logic [TAG_WIDTH-1:0] tags [LINES];
  logic [31:0]          data [LINES][LINE_WORDS];

  // Only the valid bits are reset; tag/data contents are don't-care until set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (clr_en) valid[clr_index] <= 1'b0;
      if (set_en) valid[wr_index]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (word_en) data[wr_index][wr_offset] <= wr_data;
    if (set_en)  tags[wr_index] <= wr_tag;
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[rd_index][rd_offset];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational lookup for the
// fetch port, whole-line refill from memory over a word request/done handshake.
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = 4
) (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        readyIn,
  input  logic [31:0] fetchIn,
  output logic        hit,
  output logic [31:0] insOut,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memDone,
  input  logic [31:0] memData,
  output state_t      state
);

  localparam int TAG_WIDTH  = tag_width(INDEX_WIDTH);
  localparam int TAG_LSB    = INDEX_LSB + INDEX_WIDTH;
  localparam int LINE_BITS  = 32 - INDEX_LSB;
  localparam logic [1:0] LAST_WORD = 2'(LINE_WORDS - 1);

  // Handshake: memReq/memAddr stay stable until the memory controller
  // returns memDone for one cycle with memData; each accepted word advances
  // memAddr by 4 on that same edge, and memReq drops after the fourth word.

  logic [INDEX_WIDTH-1:0] fetch_index;
  logic [TAG_WIDTH-1:0]   fetch_tag;
  logic [1:0]             fetch_offset;
  logic                   rd_valid;
  logic [TAG_WIDTH-1:0]   rd_tag;
  logic [31:0]            rd_data;

  state_t                 state_next;
  logic [1:0]             counter, counter_next;
  logic                   req_next;
  logic [31:0]            addr_next;
  logic [LINE_BITS-1:0]   base_line, base_next;
  logic                   clr_en, word_en, set_en;
  logic                   unused_bits;

  assign fetch_offset = fetchIn[OFFSET_LSB +: 2];
  assign fetch_index  = fetchIn[INDEX_LSB +: INDEX_WIDTH];
  assign fetch_tag    = fetchIn[31:TAG_LSB];
  assign unused_bits  = ^fetchIn[OFFSET_LSB-1:0];

  icache_line_array #(
    .INDEX_WIDTH(INDEX_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH)
  ) u_lines (
    .clk      (clockIn),
    .rst      (resetIn),
    .rd_index (fetch_index),
    .rd_offset(fetch_offset),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .clr_en   (clr_en),
    .clr_index(fetch_index),
    .word_en  (word_en),
    .set_en   (set_en),
    .wr_index (base_line[INDEX_WIDTH-1:0]),
    .wr_offset(counter),
    .wr_data  (memData),
    .wr_tag   (base_line[LINE_BITS-1:INDEX_WIDTH])
  );

  // The line under refill stays invalid until its tag is written, so it
  // naturally misses while other lines keep hitting.
  assign hit    = rd_valid && (rd_tag == fetch_tag);
  assign insOut = hit ? rd_data : 32'h0;

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      state     <= IDLE;
      counter   <= 2'd0;
      memReq    <= 1'b0;
      memAddr   <= 32'h0;
      base_line <= '0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      memReq    <= req_next;
      memAddr   <= addr_next;
      base_line <= base_next;
    end
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    req_next     = memReq;
    addr_next    = memAddr;
    base_next    = base_line;
    clr_en       = 1'b0;
    word_en      = 1'b0;
    set_en       = 1'b0;
    if (readyIn) begin
      case (state)
        IDLE: begin
          if (!hit) begin
            base_next    = fetchIn[31:INDEX_LSB];
            addr_next    = {fetchIn[31:INDEX_LSB], {INDEX_LSB{1'b0}}};
            req_next     = 1'b1;
            counter_next = 2'd0;
            clr_en       = 1'b1;
            state_next   = REFILL;
          end
        end
        REFILL: begin
          // fetchIn is ignored here: the latched line always completes.
          if (memDone && memReq) begin
            word_en = 1'b1;
            if (counter == LAST_WORD) begin
              set_en     = 1'b1;
              req_next   = 1'b0;
              state_next = IDLE;
            end else begin
              counter_next = counter + 2'd1;
              addr_next    = memAddr + 32'd4;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed scenarios plus random
// fetches, compared against a line-level model of cache contents.
module tb_instruction_cache;
  import instruction_cache_pkg::*;

  logic        clockIn;
  logic        resetIn;
  logic        readyIn;
  logic [31:0] fetchIn;
  logic        hit;
  logic [31:0] insOut;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memDone;
  logic [31:0] memData;
  state_t      state;

  int checks   = 0;
  int failures = 0;

  // Model: which memory line each cache slot holds.
  bit          mvalid [16];
  logic [23:0] mtag   [16];
  logic [31:0] mdata  [16][4];

  instruction_cache #(.INDEX_WIDTH(4)) dut (
    .clockIn(clockIn),
    .resetIn(resetIn),
    .readyIn(readyIn),
    .fetchIn(fetchIn),
    .hit    (hit),
    .insOut (insOut),
    .memReq (memReq),
    .memAddr(memAddr),
    .memDone(memDone),
    .memData(memData),
    .state  (state)
  );

  // ---------------- clock / watchdog ----------------
  initial clockIn = 1'b0;
  always #5 clockIn = ~clockIn;

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h0) return 32'hA + {28'h0, a[3:2]};
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  function automatic logic exp_hit(input logic [31:0] a);
    return mvalid[a[7:4]] && (mtag[a[7:4]] == a[31:8]);
  endfunction

  function automatic logic [31:0] exp_ins(input logic [31:0] a);
    return exp_hit(a) ? mdata[a[7:4]][a[3:2]] : 32'h0;
  endfunction

  // ---------------- memory-side driver ----------------
  // mode: 0 plain, 1 stall readyIn at word k_at, 2 jump fetchIn to aux at
  // word k_at, 3 hit-under-miss lookup of aux at word k_at, 4 async reset
  // at word k_at (returns with resetIn still high).
  task automatic do_refill(input logic [31:0] base, input int lat, input int mode,
                           input int k_at, input logic [31:0] aux);
    int waited = 0;
    while (memReq !== 1'b1 && waited < 8) begin
      @(negedge clockIn);
      waited++;
    end
    checks++;
    if (memReq !== 1'b1) begin
      failures++;
      $display("FAIL refill_start base=%h memReq=%b expected 1", base, memReq);
      return;
    end
    mvalid[base[7:4]] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == k_at) begin
        case (mode)
          1: begin
            readyIn = 1'b0;
            repeat (3) begin
              @(negedge clockIn);
              checks++;
              if (memReq !== 1'b1 || memAddr !== base + 32'(4 * k)) begin
                failures++;
                $display("FAIL stall_hold memReq=%b memAddr=%h expected 1 %h",
                         memReq, memAddr, base + 32'(4 * k));
              end
            end
            readyIn = 1'b1;
          end
          2: fetchIn = aux;
          3: begin
            fetchIn = aux;
            #1;
            checks++;
            if (hit !== exp_hit(aux) || insOut !== exp_ins(aux) || hit !== 1'b1 || memReq !== 1'b1) begin
              failures++;
              $display("FAIL hum_other addr=%h hit=%b ins=%h req=%b expected 1 %h 1",
                       aux, hit, insOut, memReq, exp_ins(aux));
            end
            fetchIn = {base[31:4], 4'h4};
            #1;
            checks++;
            if (hit !== 1'b0 || insOut !== 32'h0) begin
              failures++;
              $display("FAIL hum_same addr=%h hit=%b ins=%h expected 0 0", fetchIn, hit, insOut);
            end
            fetchIn = aux;
          end
          4: begin
            #2 resetIn = 1'b1;
            #1;
            checks++;
            if (memReq !== 1'b0 || hit !== 1'b0 || state !== IDLE) begin
              failures++;
              $display("FAIL async_reset memReq=%b hit=%b state=%0d expected 0 0 0",
                       memReq, hit, state);
            end
            for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
            return;
          end
          default: ;
        endcase
      end
      checks++;
      if (memReq !== 1'b1 || memAddr !== base + 32'(4 * k)) begin
        failures++;
        $display("FAIL refill_addr word=%0d memReq=%b memAddr=%h expected 1 %h",
                 k, memReq, memAddr, base + 32'(4 * k));
      end
      repeat (lat) @(negedge clockIn);
      memDone = 1'b1;
      memData = mem_word(base + 32'(4 * k));
      @(negedge clockIn);
      memDone = 1'b0;
      memData = 32'h0;
    end
    mvalid[base[7:4]] = 1'b1;
    mtag[base[7:4]]   = base[31:8];
    for (int k = 0; k < 4; k++) mdata[base[7:4]][k] = mem_word(base + 32'(4 * k));
    checks++;
    if (memReq !== 1'b0 || state !== IDLE) begin
      failures++;
      $display("FAIL refill_end memReq=%b state=%0d expected 0 0", memReq, state);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    resetIn = 1'b1; readyIn = 1'b1; fetchIn = 32'h0; memDone = 1'b0; memData = 32'h0;
    repeat (2) @(negedge clockIn);
    resetIn = 1'b0;
    #1;
    checks++;
    if (hit !== 1'b0 || insOut !== 32'h0 || memReq !== 1'b0 || memAddr !== 32'h0 || state !== IDLE) begin
      failures++;
      $display("FAIL reset_state hit=%b ins=%h req=%b addr=%h state=%0d expected 0 0 0 0 0",
               hit, insOut, memReq, memAddr, state);
    end
    @(negedge clockIn);
    checks++;
    if (memReq !== 1'b1 || memAddr !== 32'h0) begin
      failures++;
      $display("FAIL first_miss memReq=%b memAddr=%h expected 1 0", memReq, memAddr);
    end
    do_refill(32'h0, 2, 0, -1, 32'h0);
    checks++;
    if (hit !== 1'b1 || insOut !== 32'hA) begin
      failures++;
      $display("FAIL first_line_w0 hit=%b ins=%h expected 1 0000000a", hit, insOut);
    end
    fetchIn = 32'h8;
    #1;
    checks++;
    if (hit !== 1'b1 || insOut !== 32'hC) begin
      failures++;
      $display("FAIL first_line_w2 hit=%b ins=%h expected 1 0000000c", hit, insOut);
    end
  endtask

  task automatic test_evict();
    @(negedge clockIn);
    fetchIn = 32'h100;
    #1;
    checks++;
    if (hit !== 1'b0 || insOut !== 32'h0) begin
      failures++;
      $display("FAIL evict_miss hit=%b ins=%h expected 0 0", hit, insOut);
    end
    do_refill(32'h100, 1, 0, -1, 32'h0);
    fetchIn = 32'h10C;
    #1;
    checks++;
    if (hit !== 1'b1 || insOut !== exp_ins(32'h10C)) begin
      failures++;
      $display("FAIL evict_new hit=%b ins=%h expected 1 %h", hit, insOut, exp_ins(32'h10C));
    end
    fetchIn = 32'h0;
    #1;
    checks++;
    if (hit !== 1'b0) begin
      failures++;
      $display("FAIL evict_old hit=%b expected 0", hit);
    end
    do_refill(32'h0, 1, 0, -1, 32'h0);
    checks++;
    if (hit !== 1'b1 || insOut !== 32'hA) begin
      failures++;
      $display("FAIL evict_reload hit=%b ins=%h expected 1 0000000a", hit, insOut);
    end
  endtask

  task automatic test_hit_under_miss();
    @(negedge clockIn);
    fetchIn = 32'h40;
    do_refill(32'h40, 2, 3, 1, 32'h4);
    fetchIn = 32'h48;
    #1;
    checks++;
    if (hit !== 1'b1 || insOut !== exp_ins(32'h48)) begin
      failures++;
      $display("FAIL hum_done hit=%b ins=%h expected 1 %h", hit, insOut, exp_ins(32'h48));
    end
  endtask

  task automatic test_jump();
    @(negedge clockIn);
    fetchIn = 32'h84;
    do_refill(32'h80, 1, 2, 1, 32'h200);
    @(negedge clockIn);
    checks++;
    if (memReq !== 1'b1 || memAddr !== 32'h200) begin
      failures++;
      $display("FAIL jump_next memReq=%b memAddr=%h expected 1 00000200", memReq, memAddr);
    end
    do_refill(32'h200, 0, 0, -1, 32'h0);
    fetchIn = 32'h84;
    #1;
    checks++;
    if (hit !== 1'b1 || insOut !== exp_ins(32'h84) || insOut !== mem_word(32'h84)) begin
      failures++;
      $display("FAIL jump_orig hit=%b ins=%h expected 1 %h", hit, insOut, mem_word(32'h84));
    end
  endtask

  task automatic test_stall();
    @(negedge clockIn);
    fetchIn = 32'hC0;
    do_refill(32'hC0, 1, 1, 2, 32'h0);
    for (int k = 0; k < 4; k++) begin
      fetchIn = 32'hC0 + 32'(4 * k);
      #1;
      checks++;
      if (hit !== 1'b1 || insOut !== mem_word(fetchIn)) begin
        failures++;
        $display("FAIL stall_data addr=%h hit=%b ins=%h expected 1 %h",
                 fetchIn, hit, insOut, mem_word(fetchIn));
      end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] probe [5];
    probe[0] = 32'h0; probe[1] = 32'h44; probe[2] = 32'h84; probe[3] = 32'hC8; probe[4] = 32'h200;
    @(negedge clockIn);
    fetchIn = 32'h300;
    do_refill(32'h300, 1, 4, 2, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clockIn);
      fetchIn = probe[i];
      #1;
      checks++;
      if (hit !== 1'b0 || insOut !== 32'h0) begin
        failures++;
        $display("FAIL reset_lines addr=%h hit=%b ins=%h expected 0 0", fetchIn, hit, insOut);
      end
    end
    @(negedge clockIn);
    fetchIn = 32'h300;
    resetIn = 1'b0;
    #1;
    checks++;
    if (memReq !== 1'b0 || memAddr !== 32'h0) begin
      failures++;
      $display("FAIL reset_release memReq=%b memAddr=%h expected 0 0", memReq, memAddr);
    end
    do_refill(32'h300, 1, 0, -1, 32'h0);
    fetchIn = 32'h30C;
    #1;
    checks++;
    if (hit !== 1'b1 || insOut !== mem_word(32'h30C)) begin
      failures++;
      $display("FAIL reset_refill hit=%b ins=%h expected 1 %h", hit, insOut, mem_word(32'h30C));
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      @(negedge clockIn);
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      fetchIn = a;
      #1;
      checks++;
      if (hit !== exp_hit(a) || insOut !== exp_ins(a)) begin
        failures++;
        $display("FAIL rand_lookup addr=%h hit=%b ins=%h expected %b %h",
                 a, hit, insOut, exp_hit(a), exp_ins(a));
      end
      if (!exp_hit(a)) begin
        do_refill({a[31:4], 4'h0}, int'($urandom_range(0, 3)), 0, -1, 32'h0);
        #1;
        checks++;
        if (hit !== 1'b1 || insOut !== mem_word(a)) begin
          failures++;
          $display("FAIL rand_fill addr=%h hit=%b ins=%h expected 1 %h", a, hit, insOut, mem_word(a));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_evict();
    test_hit_under_miss();
    test_jump();
    test_stall();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
